// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller.
// Masks and accumulates data blocks into the running hash Y, hands each
// Y^X operand to an external GF(2^128) multiplier, tracks AAD/ciphertext bit
// lengths, finishes with the length block and presents the tag.
// Vectors use [0:127] ordering: bit 0 is the MSB of byte 0.
module ghash_ctrl (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iStart,
  input  logic [0:127] iHashkey,
  input  logic [0:127] iBlock,
  input  logic [4:0]   iBlock_bytes,
  input  logic         iBlock_aad,
  input  logic         iBlock_valid,
  output logic         oBlock_ready,
  input  logic         iFinal,
  output logic [0:127] oMul_x,
  output logic [0:127] oMul_h,
  output logic         oMul_valid,
  input  logic [0:127] iMul_result,
  input  logic         iMul_done,
  output logic [0:127] oTag,
  output logic         oTag_valid,
  output logic         oBusy,
  output logic         oErr
);

  localparam int NUM_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_MUL, S_LEN, S_MUL_LEN, S_DONE
  } state_t;

  state_t       state;
  logic [0:127] y_q;
  logic [0:127] h_q;
  logic [63:0]  len_a;
  logic [63:0]  len_c;
  logic         seen_ct;   // a ciphertext block has been taken in this message
  logic         err_arm;   // a message has started since reset; stray done counts as error

  logic [4:0]   n_eff;
  logic [63:0]  blk_bits;
  logic [0:127] x_masked;
  logic         xfer;

  assign oMul_h = h_q;

  // Effective byte count: 0 and anything above 16 mean a full block
  assign n_eff    = (iBlock_bytes == 5'd0 || iBlock_bytes > 5'd16) ? 5'd16 : iBlock_bytes;
  assign blk_bits = {56'd0, n_eff, 3'b000};
  assign xfer     = iBlock_valid && oBlock_ready;

  // Zero every byte lane at or beyond the effective byte count
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    assign x_masked[8*k +: 8] = (5'(k) < n_eff) ? iBlock[8*k +: 8] : 8'h00;
  end

  // Control FSM with all outputs registered
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state        <= S_IDLE;
      y_q          <= '0;
      h_q          <= '0;
      len_a        <= '0;
      len_c        <= '0;
      seen_ct      <= 1'b0;
      err_arm      <= 1'b0;
      oMul_x       <= '0;
      oMul_valid   <= 1'b0;
      oBlock_ready <= 1'b0;
      oTag         <= '0;
      oTag_valid   <= 1'b0;
      oBusy        <= 1'b0;
      oErr         <= 1'b0;
    end else begin
      oTag_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            h_q          <= iHashkey;
            y_q          <= '0;
            len_a        <= '0;
            len_c        <= '0;
            seen_ct      <= 1'b0;
            err_arm      <= 1'b1;
            oErr         <= 1'b0;
            oBusy        <= 1'b1;
            oBlock_ready <= 1'b1;
            state        <= S_WAIT_BLK;
          end else if (iMul_done && err_arm) begin
            oErr <= 1'b1;
          end
        end

        S_WAIT_BLK: begin
          if (iMul_done) oErr <= 1'b1;
          // A block offered together with iFinal wins; the final request waits
          if (xfer) begin
            oMul_x       <= y_q ^ x_masked;
            oMul_valid   <= 1'b1;
            oBlock_ready <= 1'b0;
            state        <= S_MUL;
            if (iBlock_aad) begin
              len_a <= len_a + blk_bits;
              if (seen_ct) oErr <= 1'b1;
            end else begin
              len_c   <= len_c + blk_bits;
              seen_ct <= 1'b1;
            end
          end else if (iFinal) begin
            oMul_x       <= y_q ^ {len_a, len_c};
            oMul_valid   <= 1'b1;
            oBlock_ready <= 1'b0;
            state        <= S_MUL_LEN;
          end
        end

        // Not entered by the normal flow (WAIT_BLK goes straight to MUL_LEN);
        // if ever reached it builds the length operand and proceeds.
        S_LEN: begin
          if (iMul_done) oErr <= 1'b1;
          oMul_x     <= y_q ^ {len_a, len_c};
          oMul_valid <= 1'b1;
          state      <= S_MUL_LEN;
        end

        S_MUL: begin
          if (iMul_done) begin
            y_q          <= iMul_result;
            oMul_valid   <= 1'b0;
            oBlock_ready <= 1'b1;
            state        <= S_WAIT_BLK;
          end
        end

        S_MUL_LEN: begin
          if (iMul_done) begin
            y_q        <= iMul_result;
            oMul_valid <= 1'b0;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          if (iMul_done) oErr <= 1'b1;
          oTag       <= y_q;
          oTag_valid <= 1'b1;
          oBusy      <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Self-checking bench for ghash_ctrl: acts as the external multiplier using a
// bit-serial GF(2^128) reference, and compares against a message-level GHASH model.
module tb_ghash_ctrl;

  logic         iClk = 1'b0;
  logic         iRst_n;
  logic         iStart;
  logic [127:0] iHashkey;
  logic [127:0] iBlock;
  logic [4:0]   iBlock_bytes;
  logic         iBlock_aad;
  logic         iBlock_valid;
  logic         oBlock_ready;
  logic         iFinal;
  logic [127:0] oMul_x;
  logic [127:0] oMul_h;
  logic         oMul_valid;
  logic [127:0] iMul_result;
  logic         iMul_done;
  logic [127:0] oTag;
  logic         oTag_valid;
  logic         oBusy;
  logic         oErr;

  ghash_ctrl dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iHashkey(iHashkey),
    .iBlock(iBlock), .iBlock_bytes(iBlock_bytes), .iBlock_aad(iBlock_aad),
    .iBlock_valid(iBlock_valid), .oBlock_ready(oBlock_ready), .iFinal(iFinal),
    .oMul_x(oMul_x), .oMul_h(oMul_h), .oMul_valid(oMul_valid),
    .iMul_result(iMul_result), .iMul_done(iMul_done), .oTag(oTag),
    .oTag_valid(oTag_valid), .oBusy(oBusy), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  int n_chk  = 0;
  int n_fail = 0;

  // message under test and the operands the model expects, in order
  logic [127:0] q_blk[$];
  logic [4:0]   q_bytes[$];
  logic         q_aad[$];
  logic [127:0] exp_x[$];
  logic [127:0] obs_x[$];

  // count multiplier operations by rising edges of oMul_valid
  int   mul_starts = 0;
  logic mv_q = 1'b0;
  always @(posedge iClk) begin
    mv_q <= oMul_valid;
    if (oMul_valid && !mv_q) mul_starts <= mul_starts + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // GCM multiplication, bit-serial, GCM bit order (bit 0 = numeric MSB)
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] mask_bytes(input logic [127:0] x, input int n);
    logic [127:0] r = x;
    int ne = (n == 0 || n > 16) ? 16 : n;
    for (int k = ne; k < 16; k++) r[127-8*k -: 8] = 8'h00;
    return r;
  endfunction

  // message-level reference: GHASH over masked blocks then the length block
  task automatic model(input logic [127:0] h, output logic [127:0] tag, output logic err);
    logic [127:0] y = '0;
    logic [127:0] xm;
    longint unsigned la = 0, lc = 0;
    bit seen = 0;
    int ne;
    err = 1'b0;
    exp_x.delete();
    foreach (q_blk[i]) begin
      ne = (q_bytes[i] == 0 || q_bytes[i] > 16) ? 16 : int'(q_bytes[i]);
      xm = y ^ mask_bytes(q_blk[i], ne);
      exp_x.push_back(xm);
      y = gmul(xm, h);
      if (q_aad[i]) begin
        la += 64'(8 * ne);
        if (seen) err = 1'b1;
      end else begin
        lc += 64'(8 * ne);
        seen = 1;
      end
    end
    xm = y ^ {la, lc};
    exp_x.push_back(xm);
    tag = gmul(xm, h);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!oBlock_ready && n < 20) begin
      tick();
      n++;
    end
    if (!oBlock_ready) chk("ready_timeout", 0, 1);
  endtask

  // play the multiplier for one operation, with a random response delay
  task automatic mul_service(input logic [127:0] ex, input logic [127:0] h);
    int d = $urandom_range(0, 3);
    chk("mul_valid", oMul_valid, 1);
    chk("mul_x", oMul_x, ex);
    chk("mul_h", oMul_h, h);
    obs_x.push_back(oMul_x);
    for (int i = 0; i < d; i++) tick();
    chk("mul_x_hold", oMul_x, ex);
    chk("mul_v_hold", oMul_valid, 1);
    iMul_done   = 1'b1;
    iMul_result = gmul(ex, h);
    tick();
    iMul_done   = 1'b0;
    iMul_result = {$urandom, $urandom, $urandom, $urandom};
    chk("mul_drop", oMul_valid, 0);
  endtask

  task automatic run_msg(input logic [127:0] h, output logic [127:0] tag, output logic err);
    logic [127:0] etag;
    logic         eerr;
    int           m0;
    model(h, etag, eerr);
    obs_x.delete();
    m0 = mul_starts;
    iHashkey = h;
    iStart   = 1'b1;
    tick();
    iStart   = 1'b0;
    iHashkey = {$urandom, $urandom, $urandom, $urandom};
    chk("busy", oBusy, 1);
    foreach (q_blk[i]) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      wait_ready();
      iBlock       = q_blk[i];
      iBlock_bytes = q_bytes[i];
      iBlock_aad   = q_aad[i];
      iBlock_valid = 1'b1;
      iFinal       = ($urandom_range(0, 3) == 0);
      tick();
      iBlock_valid = 1'b0;
      iFinal       = 1'b0;
      iBlock       = {$urandom, $urandom, $urandom, $urandom};
      chk("ready_drop", oBlock_ready, 0);
      mul_service(exp_x[i], h);
    end
    wait_ready();
    iFinal = 1'b1;
    tick();
    iFinal = 1'b0;
    mul_service(exp_x[q_blk.size()], h);
    chk("tag_early", oTag_valid, 0);
    tick();
    chk("tag_valid", oTag_valid, 1);
    chk("tag", oTag, etag);
    chk("err", oErr, eerr);
    chk("busy_end", oBusy, 0);
    tag = oTag;
    err = oErr;
    tick();
    chk("tag_pulse", oTag_valid, 0);
    chk("tag_hold", oTag, etag);
    chk("mul_count", mul_starts - m0, exp_x.size());
  endtask

  task automatic clear_msg();
    q_blk.delete();
    q_bytes.delete();
    q_aad.delete();
  endtask

  task automatic add_blk(input logic [127:0] x, input logic [4:0] n, input logic aad);
    q_blk.push_back(x);
    q_bytes.push_back(n);
    q_aad.push_back(aad);
  endtask

  logic [127:0] h_id = {1'b1, 127'd0};
  logic [127:0] t;
  logic         e;

  initial begin
    iRst_n = 1'b0; iStart = 1'b0; iHashkey = '0; iBlock = '0; iBlock_bytes = '0;
    iBlock_aad = 1'b0; iBlock_valid = 1'b0; iFinal = 1'b0;
    iMul_result = '0; iMul_done = 1'b0;
    repeat (3) tick();
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", oBlock_ready, 0);
    chk("rst_mulv", oMul_valid, 0);
    chk("rst_mulx", oMul_x, 0);
    chk("rst_mulh", oMul_h, 0);
    chk("rst_tag", oTag, 0);
    chk("rst_tagv", oTag_valid, 0);
    chk("rst_err", oErr, 0);
    iRst_n = 1'b1;
    tick();

    // empty message: only the zero length block
    clear_msg();
    run_msg({$urandom, $urandom, $urandom, $urandom}, t, e);
    chk("empty_tag", t, 0);
    chk("empty_err", e, 0);

    // identity H, one full ciphertext block
    clear_msg();
    add_blk(128'h0123456789abcdef_fedcba9876543210, 5'd16, 1'b0);
    run_msg(h_id, t, e);
    chk("id_ct_tag", t, 128'h0123456789abcdef_fedcba9876543210 ^ {64'd0, 64'd128});

    // identity H, 3-byte AAD block
    clear_msg();
    add_blk('1, 5'd3, 1'b1);
    run_msg(h_id, t, e);
    chk("aad3_x", obs_x[0], {24'hffffff, 104'd0});
    chk("aad3_tag", t, {24'hffffff, 104'd0} ^ {64'd24, 64'd0});

    // NIST GCM test case 2
    clear_msg();
    add_blk(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b0);
    run_msg(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, t, e);
    chk("nist2_tag", t, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);

    // AAD after ciphertext flags an error but still yields a tag
    clear_msg();
    add_blk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b0);
    add_blk({$urandom, $urandom, $urandom, $urandom}, 5'd7, 1'b1);
    run_msg({$urandom, $urandom, $urandom, $urandom}, t, e);
    chk("order_err", e, 1);

    // randomized messages, including byte counts 0 and >16
    for (int m = 0; m < 15; m++) begin
      clear_msg();
      for (int b = $urandom_range(0, 4); b > 0; b--)
        add_blk({$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(0, 20)),
                1'($urandom_range(0, 1)));
      run_msg({$urandom, $urandom, $urandom, $urandom}, t, e);
    end

    // reset 50 cycles into a multiply, then a late done
    clear_msg();
    iHashkey = {$urandom, $urandom, $urandom, $urandom};
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    wait_ready();
    iBlock = {$urandom, $urandom, $urandom, $urandom};
    iBlock_bytes = 5'd16;
    iBlock_aad = 1'b0;
    iBlock_valid = 1'b1;
    tick();
    iBlock_valid = 1'b0;
    chk("rmid_mulv", oMul_valid, 1);
    repeat (50) tick();
    iRst_n = 1'b0;
    tick();
    chk("rmid_mulv0", oMul_valid, 0);
    chk("rmid_busy", oBusy, 0);
    chk("rmid_tag", oTag, 0);
    chk("rmid_err", oErr, 0);
    iRst_n = 1'b1;
    iMul_done = 1'b1;
    iMul_result = {$urandom, $urandom, $urandom, $urandom};
    tick();
    iMul_done = 1'b0;
    tick();
    chk("late_err", oErr, 0);
    chk("late_busy", oBusy, 0);
    chk("late_mulv", oMul_valid, 0);
    chk("late_ready", oBlock_ready, 0);
    chk("late_tag", oTag, 0);

    // recovery after reset
    clear_msg();
    add_blk({$urandom, $urandom, $urandom, $urandom}, 5'd9, 1'b1);
    add_blk({$urandom, $urandom, $urandom, $urandom}, 5'd16, 1'b0);
    run_msg({$urandom, $urandom, $urandom, $urandom}, t, e);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
